panel_scan_ctrl: RTL and testbench
==================================

PANEL_SCAN_CTRL -- requirements
Module: panel_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 32: panel row pairs scanned per frame.
REQ-002 SHALL have parameter PWM_STEPS, default 16: bit-angle subframes per row.
REQ-003 SHALL have parameter LATCH_CYCLES, default 2: latch pulse width in clocks.
REQ-004 SHALL have parameter ON_CYCLES, default 64: display (oe_n low) time per subframe in clocks.
REQ-005 SHALL have parameter DONE_TIMEOUT, default 255: max clocks to wait for render_done.
REQ-006 SHALL have ports, one per line:
 clk_25MHz  in  1  sole clock; one clock domain, all logic on its rising edge.
 rst_n  in  1  synchronous, active-low reset.
 enable  in  1  run scanning while high.
 render_begin  out  1  one-cycle start pulse to the line renderer.
 render_done  in  1  line renderer finished shifting a row (level).
 row_addr  out  5  row address to renderer and panel.
 pwm  out  4  current PWM compare value to renderer.
 latch  out  1  panel latch strobe, active high.
 oe_n  out  1  panel output enable, active low.
 frame_done  out  1  one-cycle pulse after last row/last subframe.
 timeout_err  out  1  sticky flag; set on render_done timeout.

Function
REQ-007 SHALL implement FSM states IDLE, START, ARM, SHIFT, LATCH, DISPLAY, NEXT.
REQ-008 IDLE: oe_n=1, latch=0; SHALL go to START when enable=1.
REQ-009 START: render_begin=1 for exactly one cycle with current row_addr/pwm; then ARM.
REQ-010 ARM: one cycle, render_done ignored (renderer's done is stale-high until it clears); then SHIFT.
REQ-011 SHIFT: oe_n=1; on render_done=1 go to LATCH; timeout counter increments each cycle.
REQ-012 Timeout counter reaching DONE_TIMEOUT in SHIFT SHALL set timeout_err and go to LATCH (row step not skipped).
REQ-013 LATCH: latch=1 for LATCH_CYCLES cycles, oe_n=1; then DISPLAY.
REQ-014 DISPLAY: oe_n=0, latch=0 for ON_CYCLES cycles; then NEXT.
REQ-015 NEXT: oe_n=1; advance pwm; pwm at PWM_STEPS-1 wraps to 0 and row_addr increments; row_addr at NUM_ROWS-1 wraps to 0 and frame_done=1 this cycle.
REQ-016 NEXT SHALL go to START if enable=1, else IDLE; enable drop elsewhere SHALL NOT abort the current subframe.
REQ-017 row_addr and pwm SHALL change only in NEXT (or reset), so they are stable from START through DISPLAY.
REQ-018 latch and oe_n=0 SHALL never be asserted in the same cycle.
REQ-019 Counters SHALL be sized for their parameter via $clog2; width-mismatch truncation forbidden.
REQ-020 Latency: render_begin pulse SHALL occur one cycle after IDLE samples enable=1.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, row_addr=0, pwm=0, render_begin=0, latch=0, oe_n=1, frame_done=0, timeout_err=0, all counters 0, regardless of state.
REQ-022 Reset mid-DISPLAY SHALL blank (oe_n=1) on the same edge.
REQ-023 timeout_err SHALL clear only by reset.

Structure
REQ-024 State encoding localparams and default timing constants SHALL live in shared package panel_pkg, reused by the renderer top.
REQ-025 A sub-module pulse_timer (load value, count down, done flag) SHALL be used for LATCH, DISPLAY and timeout counting; no other sub-modules.

Verification
REQ-026 Reset, enable=1, render_done asserted 3 cycles after begin -> begin pulse 1 cycle after enable, latch high 2 cycles, oe_n low 64 cycles, pwm 0->1.
REQ-027 Full frame with NUM_ROWS=2, PWM_STEPS=2 -> row/pwm sequence (0,0),(0,1),(1,0),(1,1), frame_done pulse once, row_addr wraps to 0.
REQ-028 render_done held high continuously -> ARM ignores it; SHIFT still exits after ARM; no double begin.
REQ-029 render_done never asserted -> timeout_err=1 at 255 SHIFT cycles, sequence continues to LATCH.
REQ-030 enable dropped mid-DISPLAY -> subframe completes, NEXT then IDLE, oe_n=1, no further begin.
REQ-031 rst_n low mid-DISPLAY -> next edge oe_n=1, row_addr=0, pwm=0, state IDLE; assertion latch & !oe_n never true.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the LED panel scan controller and the renderer top:
// scan state encoding, default timing constants and small sizing helpers.
package panel_pkg;

    // Default timing and geometry constants
    localparam int DEF_NUM_ROWS     = 32;
    localparam int DEF_PWM_STEPS    = 16;
    localparam int DEF_LATCH_CYCLES = 2;
    localparam int DEF_ON_CYCLES    = 64;
    localparam int DEF_DONE_TIMEOUT = 255;

    // Fixed widths of the row address and PWM compare buses
    localparam int ROW_ADDR_W = 5;
    localparam int PWM_W      = 4;

    // Scan state encodings
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_ARM     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_LATCH   = 3'd4;
    localparam logic [2:0] ST_DISPLAY = 3'd5;
    localparam logic [2:0] ST_NEXT    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_START   = ST_START,
        S_ARM     = ST_ARM,
        S_SHIFT   = ST_SHIFT,
        S_LATCH   = ST_LATCH,
        S_DISPLAY = ST_DISPLAY,
        S_NEXT    = ST_NEXT
    } scan_state_e;

    // Bits needed to index n distinct values, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Largest of three timing values, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter: load a value, count down once per clock to zero,
// and flag done while the count sits at zero.
module pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load takes priority; otherwise decrement until the count reaches zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/panel_scan_ctrl.sv
// HUB75-style panel scan sequencer: for every row and every bit-angle
// subframe it starts the line renderer, waits for the row to be shifted,
// latches it and lights the panel for a fixed on-time.
module panel_scan_ctrl
    import panel_pkg::*;
#(
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int PWM_STEPS    = DEF_PWM_STEPS,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int ON_CYCLES    = DEF_ON_CYCLES,
    parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
    input  logic                  clk_25MHz,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  render_begin,
    input  logic                  render_done,
    output logic [ROW_ADDR_W-1:0] row_addr,
    output logic [PWM_W-1:0]      pwm,
    output logic                  latch,
    output logic                  oe_n,
    output logic                  frame_done,
    output logic                  timeout_err
);

    localparam int ROW_W = cnt_width(NUM_ROWS);
    localparam int PWM_CW = cnt_width(PWM_STEPS);
    localparam int TMR_W = cnt_width(max3(LATCH_CYCLES, ON_CYCLES, DONE_TIMEOUT) + 1);

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [PWM_CW-1:0] PWM_LAST = PWM_CW'(PWM_STEPS - 1);

    // The timer is loaded one less than the phase length because the phase
    // ends in the cycle where the count has reached zero.
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(DONE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LATCH_LOAD   = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] ON_LOAD      = TMR_W'(ON_CYCLES - 1);

    scan_state_e       state_q;
    scan_state_e       state_d;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_d;
    logic [PWM_CW-1:0] pwm_q;
    logic [PWM_CW-1:0] pwm_d;
    logic              err_q;
    logic              err_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;

    // One timer serves the shift timeout, latch width and on-time, since
    // those phases never overlap.
    pulse_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk      (clk_25MHz),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state, row/pwm stepping and panel strobes decoded from the state
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        pwm_d        = pwm_q;
        err_d        = err_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        render_begin = 1'b0;
        latch        = 1'b0;
        oe_n         = 1'b1;
        frame_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                render_begin = 1'b1;
                state_d      = S_ARM;
            end

            S_ARM: begin
                // render_done may still be high from the previous row here
                state_d  = S_SHIFT;
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_LOAD;
            end

            S_SHIFT: begin
                if (render_done) begin
                    state_d  = S_LATCH;
                    tmr_load = 1'b1;
                    tmr_val  = LATCH_LOAD;
                end else if (tmr_done) begin
                    err_d    = 1'b1;
                    state_d  = S_LATCH;
                    tmr_load = 1'b1;
                    tmr_val  = LATCH_LOAD;
                end
            end

            S_LATCH: begin
                latch = 1'b1;
                if (tmr_done) begin
                    state_d  = S_DISPLAY;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LOAD;
                end
            end

            S_DISPLAY: begin
                oe_n = 1'b0;
                if (tmr_done) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                if (pwm_q == PWM_LAST) begin
                    pwm_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end else begin
                    pwm_d = pwm_q + PWM_CW'(1);
                end
                state_d = enable ? S_START : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, scan position and sticky timeout flag registers
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            pwm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            pwm_q   <= pwm_d;
            err_q   <= err_d;
        end
    end

    assign row_addr    = ROW_ADDR_W'(row_q);
    assign pwm         = PWM_W'(pwm_q);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Self-checking bench for panel_scan_ctrl. A reference model tracks the
// subframe index and derives row/pwm, phase boundaries and frame_done from
// plain arithmetic; every cycle of a subframe is compared against it.
module tb_panel_scan_ctrl;

    localparam int NR = 2;
    localparam int PS = 2;
    localparam int LC = 2;
    localparam int OC = 64;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       render_begin;
    logic       render_done;
    logic [4:0] row_addr;
    logic [3:0] pwm;
    logic       latch;
    logic       oe_n;
    logic       frame_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Reference model: subframes completed since reset and sticky error
    int m_n   = 0;
    bit m_err = 1'b0;

    panel_scan_ctrl #(
        .NUM_ROWS     (NR),
        .PWM_STEPS    (PS),
        .LATCH_CYCLES (LC),
        .ON_CYCLES    (OC),
        .DONE_TIMEOUT (TO)
    ) dut (
        .clk_25MHz    (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .render_begin (render_begin),
        .render_done  (render_done),
        .row_addr     (row_addr),
        .pwm          (pwm),
        .latch        (latch),
        .oe_n         (oe_n),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    // 25 MHz clock
    always #20 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full subframe starting in the cycle render_begin is expected.
    // d = cycles after begin at which render_done goes (and stays) high.
    task automatic run_subframe(input int d, input bit drop_enable, input string name);
        int         k;
        bit         to;
        int         ls;
        int         ds;
        int         nx;
        logic [13:0] got;
        logic [13:0] exp;
        logic [4:0] e_row;
        logic [3:0] e_pwm;
        bit         e_fd_at_next;
        k  = 0;
        to = 1'b0;
        if (d - 1 > TO) begin
            k  = TO;
            to = 1'b1;
        end else if (d < 2) begin
            k = 1;
        end else begin
            k = d - 1;
        end
        ls = k + 2;
        ds = ls + LC;
        nx = ds + OC;
        e_row = 5'((m_n / PS) % NR);
        e_pwm = 4'(m_n % PS);
        e_fd_at_next = ((m_n % (NR * PS)) == (NR * PS - 1));
        for (int c = 0; c <= nx; c++) begin
            render_done = (c >= d);
            if (drop_enable && c == ds + 5) enable = 1'b0;
            got = {render_begin, latch, oe_n, frame_done, timeout_err, row_addr, pwm};
            exp = {(c == 0), (c >= ls && c < ds), !(c >= ds && c < nx),
                   (c == nx) && e_fd_at_next, m_err || (to && c >= ls), e_row, e_pwm};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s cycle=%0d {begin,latch,oe_n,fd,err,row,pwm} got=%b required=%b",
                         name, c, got, exp);
            end
            checks++;
            if (latch && !oe_n) begin
                errors++;
                $display("[TB] FAIL %s_overlap cycle=%0d latch=%b oe_n=%b required no overlap",
                         name, c, latch, oe_n);
            end
            tick;
        end
        m_n++;
        m_err = m_err || to;
    endtask

    // A few idle cycles: no begin, panel blanked, position held
    task automatic check_idle(input int cycles, input string name);
        logic [13:0] got;
        logic [13:0] exp;
        for (int c = 0; c < cycles; c++) begin
            got = {render_begin, latch, oe_n, frame_done, timeout_err, row_addr, pwm};
            exp = {1'b0, 1'b0, 1'b1, 1'b0, m_err, 5'((m_n / PS) % NR), 4'(m_n % PS)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s cycle=%0d got=%b required=%b", name, c, got, exp);
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        enable      = 1'b0;
        render_done = 1'b0;
        tick;
        tick;
        checks++;
        if (render_begin !== 1'b0) begin errors++; $display("[TB] FAIL reset_begin got=%b required=0", render_begin); end
        checks++;
        if (latch !== 1'b0) begin errors++; $display("[TB] FAIL reset_latch got=%b required=0", latch); end
        checks++;
        if (oe_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_oe_n got=%b required=1", oe_n); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got=%b required=0", frame_done); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got=%b required=0", timeout_err); end
        checks++;
        if (row_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_row got=%0d required=0", row_addr); end
        checks++;
        if (pwm !== 4'd0) begin errors++; $display("[TB] FAIL reset_pwm got=%0d required=0", pwm); end
        rst_n = 1'b1;
        m_n   = 0;
        m_err = 1'b0;
        tick;
        check_idle(3, "idle_disabled");
    endtask

    task automatic test_basic;
        enable = 1'b1;
        checks++;
        if (render_begin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_no_early_begin got=%b required=0", render_begin);
        end
        tick;
        run_subframe(3, 1'b0, "basic");
        checks++;
        if (pwm !== 4'd1) begin errors++; $display("[TB] FAIL basic_pwm_step got=%0d required=1", pwm); end
    endtask

    task automatic test_frame;
        for (int i = 0; i < 3; i++) run_subframe(int'($urandom_range(2, 12)), 1'b0, "frame");
        checks++;
        if (row_addr !== 5'd0 || pwm !== 4'd0) begin
            errors++;
            $display("[TB] FAIL frame_wrap got row=%0d pwm=%0d required row=0 pwm=0", row_addr, pwm);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3; i++) run_subframe(int'($urandom_range(0, 40)), 1'b0, "random");
    endtask

    task automatic test_stale_done;
        run_subframe(0, 1'b0, "stale_done");
    endtask

    task automatic test_timeout;
        run_subframe(TO, 1'b0, "late_done");
        run_subframe(1000, 1'b0, "timeout");
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag got=%b required=1", timeout_err); end
        run_subframe(int'($urandom_range(2, 20)), 1'b0, "sticky_err");
    endtask

    task automatic test_enable_drop;
        run_subframe(int'($urandom_range(2, 20)), 1'b1, "enable_drop");
        check_idle(5, "after_drop");
    endtask

    task automatic test_reset_mid_display;
        enable      = 1'b1;
        render_done = 1'b0;
        tick;
        checks++;
        if (render_begin !== 1'b1) begin errors++; $display("[TB] FAIL rmd_begin got=%b required=1", render_begin); end
        for (int c = 0; c < 16; c++) begin
            render_done = (c >= 3);
            tick;
        end
        checks++;
        if (oe_n !== 1'b0) begin errors++; $display("[TB] FAIL rmd_in_display oe_n got=%b required=0", oe_n); end
        rst_n = 1'b0;
        tick;
        checks++;
        if (oe_n !== 1'b1) begin errors++; $display("[TB] FAIL rmd_blank oe_n got=%b required=1", oe_n); end
        checks++;
        if (row_addr !== 5'd0 || pwm !== 4'd0) begin
            errors++;
            $display("[TB] FAIL rmd_position got row=%0d pwm=%0d required 0/0", row_addr, pwm);
        end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rmd_err_clear got=%b required=0", timeout_err); end
        checks++;
        if (latch !== 1'b0 || render_begin !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rmd_strobes got latch=%b begin=%b fd=%b required 0/0/0", latch, render_begin, frame_done);
        end
        tick;
        checks++;
        if (render_begin !== 1'b0 || oe_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rmd_held got begin=%b oe_n=%b required 0/1", render_begin, oe_n);
        end
        m_n   = 0;
        m_err = 1'b0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        run_subframe(int'($urandom_range(0, 30)), 1'b0, "b2b");
        run_subframe(int'($urandom_range(0, 30)), 1'b0, "b2b");
        run_subframe(int'($urandom_range(0, 30)), 1'b1, "b2b_last");
        check_idle(4, "final_idle");
    endtask

    // Scenario sequence
    initial begin
        $display("[TB] panel_scan_ctrl bench start");
        test_reset;
        test_basic;
        test_frame;
        test_random;
        test_stale_done;
        test_timeout;
        test_enable_drop;
        test_reset_mid_display;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
